bcd_sum_unit: RTL and testbench

Downstream consumer of the digit-entry stage: captures two successive 3-digit BCD operands from the input manager (`number_out`/`ready`), adds them digit-serially, and holds a 4-digit BCD sum for the display stage. Owns the "operand A, operand B, result" sequencing of the reader/adder datapath. Invalid BCD digits are rejected with an error flag.

---
 rtl/bcd_sum_unit.sv | 154 +++++++++++++++
 tb/tb_bcd_sum_unit.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/bcd_sum_unit.sv
// bcd_sum_unit: captures two 3-digit BCD operands on rising edges of
// number_valid, adds them one digit per cycle and holds the 4-digit BCD sum.
module bcd_sum_unit #(
    parameter int DIGITS = 3
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [4*DIGITS-1:0]     number_in,
    input  logic                    number_valid,
    input  logic                    clear,
    output logic [4*(DIGITS+1)-1:0] sum_out,
    output logic                    sum_valid,
    output logic                    busy,
    output logic                    operand_sel,
    output logic                    bcd_error
);

    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    typedef enum logic [1:0] {
        WAIT_A,
        WAIT_B,
        ADD,
        DONE
    } state_t;

    state_t               state;
    state_t               state_next;
    logic                 valid_prev;
    logic                 take;
    logic                 in_ok;
    logic [4*DIGITS-1:0]  op_a;
    logic [4*DIGITS-1:0]  op_b;
    logic [4*DIGITS-1:0]  acc;
    logic [4*DIGITS-1:0]  acc_next;
    logic [IDX_W-1:0]     idx;
    logic                 carry;
    logic                 last_digit;
    logic [4:0]           digit_sum;

    // True when every nibble of the operand is a legal decimal digit.
    function automatic logic digits_ok(input logic [4*DIGITS-1:0] v);
        logic ok;
        ok = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (v[4*i +: 4] > 4'd9) ok = 1'b0;
        end
        return ok;
    endfunction

    // One BCD digit add: returns {carry_out, digit}, applying the +6 correction.
    function automatic logic [4:0] bcd_digit_add(input logic [3:0] a,
                                                 input logic [3:0] b,
                                                 input logic       cin);
        logic [4:0] t;
        t = {1'b0, a} + {1'b0, b} + {4'b0000, cin};
        if (t > 5'd9) return {1'b1, t[3:0] + 4'd6};
        return {1'b0, t[3:0]};
    endfunction

    assign take        = number_valid & ~valid_prev;
    assign in_ok       = digits_ok(number_in);
    assign last_digit  = (idx == IDX_W'(DIGITS - 1));
    assign busy        = (state == ADD);
    assign operand_sel = (state == WAIT_B);

    // Current digit slice of both operands and the accumulator with it written in.
    always_comb begin
        digit_sum = bcd_digit_add(op_a[{idx, 2'b00} +: 4], op_b[{idx, 2'b00} +: 4], carry);
        acc_next  = acc;
        acc_next[{idx, 2'b00} +: 4] = digit_sum[3:0];
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!reset) state <= WAIT_A;
        else        state <= state_next;
    end

    // Next-state logic: clear overrides any take; takes in ADD are ignored.
    always_comb begin
        state_next = state;
        if (clear) begin
            state_next = WAIT_A;
        end else begin
            case (state)
                WAIT_A:  if (take && in_ok) state_next = WAIT_B;
                WAIT_B:  if (take && in_ok) state_next = ADD;
                ADD:     if (last_digit)    state_next = DONE;
                DONE:    if (take && in_ok) state_next = WAIT_B;
                default:                    state_next = WAIT_A;
            endcase
        end
    end

    // Operand capture, digit-serial accumulation and result/flag registers.
    always_ff @(posedge clk) begin
        if (!reset) begin
            valid_prev <= 1'b0;
            op_a       <= '0;
            op_b       <= '0;
            acc        <= '0;
            idx        <= '0;
            carry      <= 1'b0;
            sum_out    <= '0;
            sum_valid  <= 1'b0;
            bcd_error  <= 1'b0;
        end else begin
            valid_prev <= number_valid;
            if (clear) begin
                sum_valid <= 1'b0;
                bcd_error <= 1'b0;
            end else begin
                case (state)
                    WAIT_A, DONE: begin
                        if (take) begin
                            if (in_ok) begin
                                op_a      <= number_in;
                                bcd_error <= 1'b0;
                                sum_valid <= 1'b0;
                            end else begin
                                bcd_error <= 1'b1;
                            end
                        end
                    end
                    WAIT_B: begin
                        if (take) begin
                            if (in_ok) begin
                                op_b      <= number_in;
                                idx       <= '0;
                                carry     <= 1'b0;
                                acc       <= '0;
                                bcd_error <= 1'b0;
                            end else begin
                                bcd_error <= 1'b1;
                            end
                        end
                    end
                    ADD: begin
                        acc   <= acc_next;
                        carry <= digit_sum[4];
                        idx   <= idx + IDX_W'(1);
                        if (last_digit) begin
                            sum_out   <= {3'b000, digit_sum[4], acc_next};
                            sum_valid <= 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_bcd_sum_unit.sv
// Scoreboard bench for bcd_sum_unit: stimulus pushes expected sums and
// completion cycles, a monitor pops them whenever sum_valid rises.
module tb_bcd_sum_unit;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [11:0] number_in = '0;
    logic        number_valid = 1'b0;
    logic        clear = 1'b0;
    logic [15:0] sum_out;
    logic        sum_valid;
    logic        busy;
    logic        operand_sel;
    logic        bcd_error;

    int total = 0;
    int passed = 0;
    int cyc = 0;
    logic sv_prev = 1'b0;

    typedef struct {
        logic [15:0] sum;
        int          cyc;
    } exp_t;
    exp_t exp_q[$];

    bcd_sum_unit #(.DIGITS(3)) dut (
        .clk          (clk),
        .reset        (reset),
        .number_in    (number_in),
        .number_valid (number_valid),
        .clear        (clear),
        .sum_out      (sum_out),
        .sum_valid    (sum_valid),
        .busy         (busy),
        .operand_sel  (operand_sel),
        .bcd_error    (bcd_error)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Reference model: BCD <-> integer, sum computed in plain decimal arithmetic.
    function automatic int bcd2int(input logic [15:0] v);
        int r = 0;
        for (int i = 3; i >= 0; i--) r = r * 10 + int'(v[4*i +: 4]);
        return r;
    endfunction

    function automatic logic [15:0] int2bcd(input int n);
        logic [15:0] r = '0;
        int x = n;
        for (int i = 0; i < 4; i++) begin
            r[4*i +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    function automatic logic [11:0] rand_bcd();
        logic [11:0] r;
        for (int i = 0; i < 3; i++) r[4*i +: 4] = 4'($urandom_range(0, 9));
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act === req) passed++;
        else $display("FAIL %s got=%0h required=%0h (cycle %0d)", name, act, req, cyc);
    endtask

    // Monitor: every new result is compared against the oldest expectation.
    always @(negedge clk) begin
        if (sum_valid && !sv_prev) begin
            if (exp_q.size() == 0) begin
                total++;
                $display("FAIL unexpected_sum got=%0h required=none", sum_out);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("sum_value", 32'(sum_out), 32'(e.sum));
                check("sum_latency", 32'(cyc), 32'(e.cyc));
            end
        end
        sv_prev = sum_valid;
    end

    task automatic take(input logic [11:0] v);
        @(negedge clk);
        number_in = v;
        number_valid = 1'b1;
        @(negedge clk);
        number_valid = 1'b0;
    endtask

    task automatic take_b(input logic [11:0] a, input logic [11:0] b);
        @(negedge clk);
        number_in = b;
        number_valid = 1'b1;
        exp_q.push_back('{sum: int2bcd(bcd2int({4'h0, a}) + bcd2int({4'h0, b})), cyc: cyc + 4});
        @(negedge clk);
        number_valid = 1'b0;
        check("busy_add1", 32'(busy), 32'd1);
        check("sum_valid_add1", 32'(sum_valid), 32'd0);
        @(negedge clk);
        check("busy_add2", 32'(busy), 32'd1);
        @(negedge clk);
        check("busy_add3", 32'(busy), 32'd1);
        @(negedge clk);
        check("busy_done", 32'(busy), 32'd0);
        check("sum_valid_done", 32'(sum_valid), 32'd1);
        check("opsel_done", 32'(operand_sel), 32'd0);
    endtask

    task automatic pair(input logic [11:0] a, input logic [11:0] b);
        take(a);
        check("opsel_after_a", 32'(operand_sel), 32'd1);
        take_b(a, b);
    endtask

    task automatic pulse_clear();
        @(negedge clk);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_sum_out"}, 32'(sum_out), 32'd0);
        check({tag, "_sum_valid"}, 32'(sum_valid), 32'd0);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_opsel"}, 32'(operand_sel), 32'd0);
        check({tag, "_bcd_error"}, 32'(bcd_error), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "timeout");
    end

    initial begin
        repeat (3) @(negedge clk);
        check_reset_values("reset");
        reset = 1'b1;

        pair(12'h123, 12'h456);
        pair(12'h999, 12'h999);
        pair(12'h005, 12'h095);

        // Level held high: exactly one capture.
        pulse_clear();
        @(negedge clk);
        number_in = 12'h111;
        number_valid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check("held_opsel", 32'(operand_sel), 32'd1);
        end
        number_valid = 1'b0;
        take_b(12'h111, 12'h222);

        // Invalid digits in A and in B.
        pulse_clear();
        take(12'h1A3);
        check("bad_a_err", 32'(bcd_error), 32'd1);
        check("bad_a_opsel", 32'(operand_sel), 32'd0);
        take(12'h200);
        check("good_a_err", 32'(bcd_error), 32'd0);
        check("good_a_opsel", 32'(operand_sel), 32'd1);
        take(12'h2F0);
        check("bad_b_err", 32'(bcd_error), 32'd1);
        check("bad_b_opsel", 32'(operand_sel), 32'd1);
        take_b(12'h200, 12'h300);
        check("good_b_err", 32'(bcd_error), 32'd0);

        // Reset during the second ADD cycle.
        take(12'h111);
        @(negedge clk);
        number_in = 12'h222;
        number_valid = 1'b1;
        @(negedge clk);
        number_valid = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check_reset_values("midadd_reset");
        reset = 1'b1;
        pair(12'h010, 12'h020);

        // New A in DONE keeps old sum; clear beats a simultaneous take.
        pair(12'h123, 12'h456);
        take(12'h001);
        check("done_take_valid", 32'(sum_valid), 32'd0);
        check("done_take_sum", 32'(sum_out), 32'h0579);
        check("done_take_opsel", 32'(operand_sel), 32'd1);
        @(negedge clk);
        number_in = 12'h005;
        number_valid = 1'b1;
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        number_valid = 1'b0;
        check("clear_take_opsel", 32'(operand_sel), 32'd0);
        check("clear_take_busy", 32'(busy), 32'd0);
        pair(12'h002, 12'h003);

        // Random valid operand pairs.
        for (int n = 0; n < 25; n++) begin
            logic [11:0] a;
            logic [11:0] b;
            a = rand_bcd();
            b = rand_bcd();
            pair(a, b);
        end

        repeat (4) @(negedge clk);
        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
